// File: rtl/cv32e40p_hwloop_jump_ctrl.sv
// Hardware-loop jump controller at the IF/ID boundary.
// Matches the fetch PC against loop end addresses, issues zero-overhead jumps
// to the loop start, and tracks in-flight end-of-loop instructions so that
// the register-file counters are decremented only when those instructions
// retire in ID.
module cv32e40p_hwloop_jump_ctrl #(
  parameter int N_REGS = 2,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REGS-1:0][31:0] hwlp_start_addr_i,
  input  logic [N_REGS-1:0][31:0] hwlp_end_addr_i,
  input  logic [N_REGS-1:0][31:0] hwlp_counter_i,
  input  logic [31:0]             if_pc_i,
  input  logic                    if_valid_i,
  input  logic                    if_ready_i,
  output logic                    if_hold_o,
  output logic                    hwlp_jump_o,
  output logic [31:0]             hwlp_target_o,
  output logic                    if_hwlp_tag_o,
  input  logic                    id_retire_i,
  input  logic                    id_hwlp_tag_i,
  input  logic                    flush_i,
  output logic [N_REGS-1:0]       hwlp_dec_cnt_o,
  output logic [CNT_W-1:0]        hwlp_pending_o
);

  localparam int IDW  = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [PTRW-1:0]  LAST_PTR  = PTRW'(DEPTH - 1);

  logic [IDW-1:0]   q_q [DEPTH];
  logic [IDW-1:0]   q_d [DEPTH];
  logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] pending_q [N_REGS];
  logic [CNT_W-1:0] pending_d [N_REGS];

  logic [N_REGS-1:0][31:0] cnt_eff;
  logic [N_REGS-1:0]       match;
  logic                    any_match;
  logic [IDW-1:0]          sel;
  logic [IDW-1:0]          head_id;
  logic                    pop;
  logic                    push;
  logic                    transfer;
  logic                    full_post_pop;

  // Effective counts (committed minus in-flight) and per-loop end-address match.
  always_comb begin
    for (int i = 0; i < N_REGS; i++) begin
      cnt_eff[i] = hwlp_counter_i[i] - 32'(pending_q[i]);
      match[i]   = if_valid_i && (if_pc_i == hwlp_end_addr_i[i]) && (cnt_eff[i] != 32'd0);
    end
  end

  // Lowest matching index (innermost loop) wins.
  always_comb begin
    sel       = '0;
    any_match = 1'b0;
    for (int i = N_REGS - 1; i >= 0; i--) begin
      if (match[i]) begin
        sel       = IDW'(i);
        any_match = 1'b1;
      end
    end
  end

  // Handshake, hold, jump and decrement outputs.
  always_comb begin
    head_id        = q_q[rd_ptr_q];
    pop            = id_retire_i && id_hwlp_tag_i && (count_q != '0);
    // A same-cycle pop frees a slot, so fullness is judged after the pop.
    full_post_pop  = ((count_q - CNT_W'(pop)) == DEPTH_C);
    if_hold_o      = any_match && full_post_pop && !flush_i;
    transfer       = if_valid_i && if_ready_i && !if_hold_o;
    push           = transfer && any_match && !flush_i;
    if_hwlp_tag_o  = push;
    hwlp_jump_o    = push && (cnt_eff[sel] >= 32'd2);
    hwlp_target_o  = hwlp_jump_o ? hwlp_start_addr_i[sel] : 32'd0;
    hwlp_dec_cnt_o = '0;
    // The retiring instruction is older than anything a flush kills, so its
    // decrement is still issued.
    if (pop) hwlp_dec_cnt_o[head_id] = 1'b1;
    hwlp_pending_o = count_q;
  end

  // Next-state for the loop-id queue and the per-loop pending counters.
  always_comb begin
    q_d      = q_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    for (int i = 0; i < N_REGS; i++) begin
      pending_d[i] = pending_q[i]
                   + CNT_W'(push && (sel == IDW'(i)))
                   - CNT_W'(pop && (head_id == IDW'(i)));
    end
    if (push) begin
      q_d[wr_ptr_q] = sel;
      wr_ptr_d      = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTRW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTRW'(1);
    end
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      for (int i = 0; i < N_REGS; i++) pending_d[i] = '0;
    end
  end

  // State registers; reset discards in-flight entries without decrementing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++)  q_q[i]       <= '0;
      for (int i = 0; i < N_REGS; i++) pending_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < DEPTH; i++)  q_q[i]       <= q_d[i];
      for (int i = 0; i < N_REGS; i++) pending_q[i] <= pending_d[i];
    end
  end

`ifndef SYNTHESIS
  a_dec_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(hwlp_dec_cnt_o));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
    (id_retire_i && id_hwlp_tag_i) |-> (count_q != '0));
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    push |-> ((count_q != DEPTH_C) || pop));
`endif

endmodule

// File: tb/tb_cv32e40p_hwloop_jump_ctrl.sv
// Directed bench for the hardware-loop jump controller.
module tb_cv32e40p_hwloop_jump_ctrl;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0][31:0]  start_a, end_a, cnt;
  logic [31:0]       pc;
  logic              valid, ready, retire, rtag, flush;
  logic              hold, jump, tag;
  logic [31:0]       target;
  logic [1:0]        dec;
  logic [1:0]        pend;

  int tests = 0;
  int fails = 0;

  cv32e40p_hwloop_jump_ctrl #(.N_REGS(2), .DEPTH(2)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .hwlp_start_addr_i (start_a),
    .hwlp_end_addr_i   (end_a),
    .hwlp_counter_i    (cnt),
    .if_pc_i           (pc),
    .if_valid_i        (valid),
    .if_ready_i        (ready),
    .if_hold_o         (hold),
    .hwlp_jump_o       (jump),
    .hwlp_target_o     (target),
    .if_hwlp_tag_o     (tag),
    .id_retire_i       (retire),
    .id_hwlp_tag_i     (rtag),
    .flush_i           (flush),
    .hwlp_dec_cnt_o    (dec),
    .hwlp_pending_o    (pend)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid = 0; ready = 1; retire = 0; rtag = 0; flush = 0; pc = 32'h0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    start_a = '0; end_a = '0; cnt = '0;
    #12;
    tests++; if (pend !== 2'd0) begin fails++; $display("FAIL reset_pending: got %0d want 0", pend); end
    tests++; if (dec !== 2'b00) begin fails++; $display("FAIL reset_dec: got %b want 00", dec); end
    rst_n = 1;
    step();
    tests++; if ({hold, jump, tag} !== 3'b000) begin fails++; $display("FAIL idle_ctrl: got %b want 000", {hold, jump, tag}); end
    tests++; if (target !== 32'h0) begin fails++; $display("FAIL idle_target: got %h want 0", target); end
    tests++; if ({dec, pend} !== 4'b0000) begin fails++; $display("FAIL idle_dec_pend: got %b want 0000", {dec, pend}); end
  endtask

  task automatic test_single_loop();
    start_a[0] = 32'h100; end_a[0] = 32'h10C; cnt[0] = 32'd3;
    start_a[1] = 32'h900; end_a[1] = 32'hFF0; cnt[1] = 32'd0;
    for (int k = 0; k < 3; k++) begin
      idle(); valid = 1; pc = 32'h10C; #1;
      tests++; if (jump !== (k < 2)) begin fails++; $display("FAIL single_jump%0d: got %b want %b", k, jump, (k < 2)); end
      tests++; if (target !== ((k < 2) ? 32'h100 : 32'h0)) begin fails++; $display("FAIL single_target%0d: got %h", k, target); end
      tests++; if ({tag, hold} !== 2'b10) begin fails++; $display("FAIL single_tag%0d: got %b want 10", k, {tag, hold}); end
      step();
      idle(); retire = 1; rtag = 1; #1;
      tests++; if (dec !== 2'b01 || pend !== 2'd1) begin fails++; $display("FAIL single_dec%0d: got dec=%b pend=%0d want 01/1", k, dec, pend); end
      step();
      cnt[0] = cnt[0] - 1;
      idle(); #1;
      tests++; if (dec !== 2'b00 || pend !== 2'd0) begin fails++; $display("FAIL single_pulse%0d: got dec=%b pend=%0d want 00/0", k, dec, pend); end
    end
    idle(); valid = 1; pc = 32'h10C; #1;
    tests++; if ({tag, jump} !== 2'b00) begin fails++; $display("FAIL single_exhausted: got %b want 00", {tag, jump}); end
    step(); idle();
  endtask

  task automatic test_lookahead();
    cnt[0] = 32'd2;
    idle(); valid = 1; pc = 32'h10C; #1;
    tests++; if (jump !== 1'b1 || target !== 32'h100) begin fails++; $display("FAIL look_first: got jump=%b tgt=%h want 1/100", jump, target); end
    step();
    #1;
    tests++; if (jump !== 1'b0 || tag !== 1'b1) begin fails++; $display("FAIL look_second: got jump=%b tag=%b want 0/1", jump, tag); end
    step();
    idle(); #1;
    tests++; if (pend !== 2'd2) begin fails++; $display("FAIL look_pending: got %0d want 2", pend); end
    for (int k = 0; k < 2; k++) begin
      retire = 1; rtag = 1; #1;
      tests++; if (dec !== 2'b01) begin fails++; $display("FAIL look_dec%0d: got %b want 01", k, dec); end
      step();
      cnt[0] = cnt[0] - 1;
    end
    idle(); #1;
    tests++; if (pend !== 2'd0 || dec !== 2'b00) begin fails++; $display("FAIL look_drain: got pend=%0d dec=%b want 0/00", pend, dec); end
  endtask

  task automatic test_nesting();
    start_a[0] = 32'h180; end_a[0] = 32'h200; cnt[0] = 32'd2;
    start_a[1] = 32'h140; end_a[1] = 32'h200; cnt[1] = 32'd5;
    idle(); valid = 1; pc = 32'h200; #1;
    tests++; if (jump !== 1'b1 || target !== 32'h180) begin fails++; $display("FAIL nest_target: got jump=%b tgt=%h want 1/180", jump, target); end
    step();
    idle(); retire = 1; rtag = 1; #1;
    tests++; if (dec !== 2'b01) begin fails++; $display("FAIL nest_dec: got %b want 01", dec); end
    step();
    cnt[0] = 32'd0;
    idle(); valid = 1; pc = 32'h200; #1;
    tests++; if (jump !== 1'b1 || target !== 32'h140) begin fails++; $display("FAIL nest_outer_target: got jump=%b tgt=%h want 1/140", jump, target); end
    step();
    idle(); retire = 1; rtag = 1; #1;
    tests++; if (dec !== 2'b10) begin fails++; $display("FAIL nest_outer_dec: got %b want 10", dec); end
    step();
    cnt[1] = 32'd4;
    idle(); #1;
  endtask

  task automatic test_queue_full();
    start_a[0] = 32'h100; end_a[0] = 32'h10C; cnt[0] = 32'd5;
    idle(); valid = 1; pc = 32'h10C;
    step(); step();
    #1;
    tests++; if (hold !== 1'b1 || tag !== 1'b0 || jump !== 1'b0) begin fails++; $display("FAIL full_hold: got hold=%b tag=%b jump=%b want 1/0/0", hold, tag, jump); end
    tests++; if (pend !== 2'd2) begin fails++; $display("FAIL full_pend: got %0d want 2", pend); end
    step();
    tests++; if (pend !== 2'd2) begin fails++; $display("FAIL full_no_push: got %0d want 2", pend); end
    retire = 1; rtag = 1; #1;
    tests++; if (hold !== 1'b0 || tag !== 1'b1 || jump !== 1'b1 || target !== 32'h100) begin fails++; $display("FAIL full_swap: got hold=%b tag=%b jump=%b tgt=%h want 0/1/1/100", hold, tag, jump, target); end
    tests++; if (dec !== 2'b01) begin fails++; $display("FAIL full_swap_dec: got %b want 01", dec); end
    step();
    cnt[0] = 32'd4;
    idle(); #1;
    tests++; if (pend !== 2'd2) begin fails++; $display("FAIL full_occupancy: got %0d want 2", pend); end
    retire = 1; rtag = 1;
    step(); cnt[0] = 32'd3;
    step(); cnt[0] = 32'd2;
    idle(); #1;
    tests++; if (pend !== 2'd0) begin fails++; $display("FAIL full_drain: got %0d want 0", pend); end
  endtask

  task automatic test_flush();
    cnt[0] = 32'd5;
    idle(); valid = 1; pc = 32'h10C;
    step(); step();
    flush = 1; retire = 1; rtag = 1; #1;
    tests++; if (dec !== 2'b01) begin fails++; $display("FAIL flush_dec: got %b want 01", dec); end
    tests++; if ({jump, tag, hold} !== 3'b000) begin fails++; $display("FAIL flush_suppress: got %b want 000", {jump, tag, hold}); end
    step();
    cnt[0] = 32'd1;
    idle(); #1;
    tests++; if (pend !== 2'd0 || dec !== 2'b00) begin fails++; $display("FAIL flush_clear: got pend=%0d dec=%b want 0/00", pend, dec); end
    valid = 1; pc = 32'h10C; #1;
    tests++; if (tag !== 1'b1 || jump !== 1'b0) begin fails++; $display("FAIL flush_cnt_eff: got tag=%b jump=%b want 1/0", tag, jump); end
    step();
    idle(); retire = 1; rtag = 1;
    step();
    cnt[0] = 32'd0;
    idle(); #1;
  endtask

  task automatic test_reset_mid();
    cnt[0] = 32'd5;
    idle(); valid = 1; pc = 32'h10C;
    step(); step();
    idle(); retire = 1; rtag = 1; #1;
    rst_n = 0; #1;
    tests++; if (pend !== 2'd0 || dec !== 2'b00) begin fails++; $display("FAIL rst_mid: got pend=%0d dec=%b want 0/00", pend, dec); end
    idle();
    step();
    #2 rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      tests++; if (dec !== 2'b00 || pend !== 2'd0) begin fails++; $display("FAIL rst_after%0d: got dec=%b pend=%0d want 00/0", k, dec, pend); end
    end
  endtask

  initial begin
    test_reset();
    test_single_loop();
    test_lookahead();
    test_nesting();
    test_queue_full();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
